// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: drives an external up/down address counter and one single-port SRAM,
// checks read data and reports done/fail. Optional MBIST_FAIL_STOP_EN stops on first miscompare.
module mbist_march_ctrl #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 8,
  parameter int unsigned ADDR_MAX = 2**AW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [7:0]    fail_cnt,
  output logic          cnt_cen,
  output logic          cnt_ld,
  output logic          cnt_ud,
  output logic [AW-1:0] cnt_din,
  input  logic [AW-1:0] cnt_q,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] AddrMax = AW'(ADDR_MAX);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StWo    = 3'd2;
  localparam logic [2:0] StRd    = 3'd3;
  localparam logic [2:0] StWr    = 3'd4;
  localparam logic [2:0] StRo    = 3'd5;
  localparam logic [2:0] StFlush = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [2:0]    elem_q, elem_d;
  logic [AW-1:0] rd_addr_q;
  logic          ro_pend_q;
  logic          fail_q;
  logic [AW-1:0] fail_addr_q;
  logic [7:0]    fail_cnt_q;

  logic up, term, exp_bg, wr_bg, cmp_en, miscmp, restart;

  // Elements M0-M2 sweep up, M3-M5 sweep down
  assign up      = (elem_q < 3'd3);
  assign term    = up ? (cnt_q == AddrMax) : (cnt_q == '0);
  assign exp_bg  = (elem_q == 3'd2) || (elem_q == 3'd4);
  assign wr_bg   = (elem_q == 3'd1) || (elem_q == 3'd3);
  assign restart = ((state_q == StIdle) || (state_q == StDone)) && start;

  // Read data lags the read by one cycle: WR checks RD, RO/FLUSH check the previous RO
  assign cmp_en = (state_q == StWr) || ((state_q == StRo) && ro_pend_q) || (state_q == StFlush);
  assign miscmp = cmp_en && (mem_rdata != {DW{exp_bg}});

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          elem_d  = 3'd0;
        end
      end
      StLoad: begin
        if (elem_q == 3'd0)      state_d = StWo;
        else if (elem_q == 3'd5) state_d = StRo;
        else                     state_d = StRd;
      end
      StWo: begin
        if (term) begin
          state_d = StLoad;
          elem_d  = elem_q + 3'd1;
        end
      end
      StRd: state_d = StWr;
      StWr: begin
        if (term) begin
          state_d = StLoad;
          elem_d  = elem_q + 3'd1;
        end else begin
          state_d = StRd;
        end
      end
      StRo:    if (term) state_d = StFlush;
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
`ifdef MBIST_FAIL_STOP_EN
    if (miscmp) state_d = StDone;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      elem_q    <= 3'd0;
      rd_addr_q <= '0;
      ro_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      ro_pend_q <= (state_q == StRo);
      if ((state_q == StRd) || (state_q == StRo)) rd_addr_q <= cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_cnt_q  <= 8'd0;
    end else if (restart) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_cnt_q  <= 8'd0;
    end else if (miscmp) begin
      fail_q <= 1'b1;
      if (!fail_q) fail_addr_q <= rd_addr_q;
      if (fail_cnt_q != 8'hff) fail_cnt_q <= fail_cnt_q + 8'd1;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle) && (state_q != StDone);
    done      = (state_q == StDone);
    fail      = fail_q;
    fail_addr = fail_addr_q;
    fail_cnt  = fail_cnt_q;
    cnt_ld    = (state_q == StLoad);
    cnt_cen   = (state_q == StLoad) || (state_q == StWo) || (state_q == StRo) ||
                ((state_q == StWr) && !term);
    cnt_ud    = up;
    cnt_din   = up ? '0 : AddrMax;
    mem_cs    = (state_q == StWo) || (state_q == StRd) || (state_q == StWr) || (state_q == StRo);
    mem_we    = (state_q == StWo) || (state_q == StWr);
    mem_addr  = cnt_q;
    mem_wdata = {DW{wr_bg}};
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with AW=3: models the address counter and an 8x8 SRAM
// with an optional stuck-at-1 on bit 0 of address 5.
module tb_mbist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, fail;
  logic [2:0] fail_addr;
  logic [7:0] fail_cnt;
  logic       cnt_cen, cnt_ld, cnt_ud;
  logic [2:0] cnt_din;
  logic [2:0] cnt_q = 3'd0;
  logic       mem_cs, mem_we;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'd0;
  logic       fault = 1'b0;
  logic [7:0] mem [8];

  int checks = 0;
  int failures = 0;
  int cycles;
  int log_addr [200];
  int log_ld   [200];
  int log_din  [200];
  int log_ud   [200];
  int log_we   [200];
  int log_busy [200];
  int log_fail [200];

  mbist_march_ctrl #(.AW(3), .DW(8), .ADDR_MAX(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_cnt  (fail_cnt),
    .cnt_cen   (cnt_cen),
    .cnt_ld    (cnt_ld),
    .cnt_ud    (cnt_ud),
    .cnt_din   (cnt_din),
    .cnt_q     (cnt_q),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_cen) cnt_q <= cnt_ld ? cnt_din : (cnt_ud ? cnt_q + 3'd1 : cnt_q - 3'd1);
  end

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr] | {7'd0, (fault && (mem_addr == 3'd5))};
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic record(input int c);
    log_addr[c] = int'(mem_addr);
    log_ld[c]   = int'(cnt_ld);
    log_din[c]  = int'(cnt_din);
    log_ud[c]   = int'(cnt_ud);
    log_we[c]   = int'(mem_we);
    log_busy[c] = int'(busy);
    log_fail[c] = int'(fail);
  endtask

  // Cycle 1 is the LOAD cycle after the start-sampling edge; returns edges until DONE.
  task automatic run(input bit hold, output int n);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    record(1);
    if (!hold) start = 1'b0;
    while (n < 500) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      if (n < 198) record(n + 1);
    end
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_fail"}, int'(fail), 0);
    check({tag, "_faddr"}, int'(fail_addr), 0);
    check({tag, "_fcnt"}, int'(fail_cnt), 0);
    check({tag, "_ctl"}, int'({cnt_cen, cnt_ld, mem_cs, mem_we}), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fault-free march with counter-interface checks
    run(1'b0, cycles);
    check("t1_len", cycles, 87);
    check("t1_done", int'(done), 1);
    check("t1_busy", int'(busy), 0);
    check("t1_fail", int'(fail), 0);
    check("t1_fcnt", int'(fail_cnt), 0);
    check("m0_load", log_ld[1] * 100 + log_din[1] * 10 + log_ud[1], 101);
    check("m0_busy", log_busy[1], 1);
    for (int c = 2; c <= 9; c++) begin
      check("m0_addr", log_addr[c], c - 2);
      check("m0_we", log_we[c], 1);
    end
    check("m3_load", log_ld[44] * 100 + log_din[44] * 10 + log_ud[44], 170);
    for (int c = 45; c <= 60; c++) begin
      check("m3_addr", log_addr[c], 7 - (c - 45) / 2);
      check("m3_ud", log_ud[c], 0);
    end

    // Stuck-at-1 on bit 0 of address 5
    fault = 1'b1;
    run(1'b0, cycles);
`ifdef MBIST_FAIL_STOP_EN
    check("t2_len", cycles, 22);
    check("t2_fcnt", int'(fail_cnt), 1);
`else
    check("t2_len", cycles, 87);
    check("t2_fcnt", int'(fail_cnt), 3);
`endif
    check("t2_fail", int'(fail), 1);
    check("t2_faddr", int'(fail_addr), 5);
    check("t2_done", int'(done), 1);

    // Start held high from DONE: restart clears fail, no restart while busy
    fault = 1'b0;
    run(1'b1, cycles);
    check("t6_clr", log_fail[1], 0);
    check("t6_len", cycles, 87);
    check("t6_fail", int'(fail), 0);
    check("t6_done", int'(done), 1);

    // Reset mid-M2 at address 4 (RD of address 4 is cycle 36)
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    check("t5_pre_q", int'(cnt_q), 4);
    check("t5_pre_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("t5_rst");
    @(posedge clk);
    #1;
    check_idle_outputs("t5_hold");
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, cycles);
    check("t5_len", cycles, 87);
    check("t5_fail", int'(fail), 0);
    check("t5_fcnt", int'(fail_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
